// File: rtl/nes_controller_emulator_if.sv
`default_nettype none
// ============================================================================
// Module   : nes_controller_emulator_if
// Brief    : Pad-side NES serial bus plus the local button and status signals.
// Revision : 1.0 - initial release
// ============================================================================
interface nes_controller_emulator_if;

  logic       nesLatch;
  logic       nesClk;
  logic [7:0] buttons;
  logic       nesData;
  logic       frameDone;
  logic [3:0] bitIndex;
  logic [7:0] frameCount;

  // master: console/host side driving latch, clock and the button source
  modport master (
    output nesLatch,
    output nesClk,
    output buttons,
    input  nesData,
    input  frameDone,
    input  bitIndex,
    input  frameCount
  );

  modport slave (
    input  nesLatch,
    input  nesClk,
    input  buttons,
    output nesData,
    output frameDone,
    output bitIndex,
    output frameCount
  );

endinterface

`default_nettype wire

// File: rtl/nes_controller_emulator.sv
`default_nettype none
// ============================================================================
// Module   : nes_controller_emulator
// Brief    : CD4021-style NES pad endpoint, fully synchronous to clk.
// Revision : 1.0 - initial release
// ============================================================================
module nes_controller_emulator #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  nes_controller_emulator_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] latch_sync_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic                   latch_prev_q;
  logic                   clk_prev_q;
  logic                   latch_rise_q;
  logic                   latch_fall_q;
  logic                   clk_rise_q;

  logic                   w_latch_s;
  logic                   w_clk_s;
  logic [3:0]             w_idx_inc;
  logic                   w_load;

  state_t                 state_q, state_d;
  logic [7:0]             shadow_q, shadow_d;
  logic                   data_q, data_d;
  logic [3:0]             idx_q, idx_d;
  logic                   done_q, done_d;
  logic [7:0]             count_q, count_d;

  assign w_latch_s = latch_sync_q[SYNC_STAGES-1];
  assign w_clk_s   = clk_sync_q[SYNC_STAGES-1];
  assign w_idx_inc = idx_q + 4'd1;

  // Clock chain resets high so an idle-high nesClk yields no edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_sync_q <= '0;
      clk_sync_q   <= '1;
      latch_prev_q <= 1'b0;
      clk_prev_q   <= 1'b1;
      latch_rise_q <= 1'b0;
      latch_fall_q <= 1'b0;
      clk_rise_q   <= 1'b0;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], bus.nesLatch};
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], bus.nesClk};
      latch_prev_q <= w_latch_s;
      clk_prev_q   <= w_clk_s;
      latch_rise_q <= w_latch_s & ~latch_prev_q;
      latch_fall_q <= ~w_latch_s & latch_prev_q;
      clk_rise_q   <= w_clk_s & ~clk_prev_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    count_d  = count_q;

    unique case (state_q)
      S_IDLE: begin
        data_d = 1'b1;
        idx_d  = 4'd0;
      end
      S_LOAD: begin
        if (latch_fall_q) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (clk_rise_q) begin
          idx_d = w_idx_inc;
          if (w_idx_inc[3]) begin
            data_d  = 1'b1;
            done_d  = 1'b1;
            count_d = count_q + 8'd1;
            state_d = S_DONE;
          end else begin
            data_d = ~shadow_q[w_idx_inc[2:0]];
          end
        end
      end
      S_DONE: begin
        data_d = 1'b1;
        idx_d  = 4'd8;
      end
    endcase

    // Parallel load wins over any shift, including a same-cycle clock edge.
    w_load = latch_rise_q | ((state_q == S_IDLE) & latch_prev_q) | (state_q == S_LOAD);
    if (w_load) begin
      shadow_d = bus.buttons;
      idx_d    = 4'd0;
      data_d   = ~bus.buttons[0];
      done_d   = 1'b0;
      count_d  = count_q;
      if (latch_rise_q || (state_q == S_IDLE)) begin
        state_d = S_LOAD;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shadow_q <= 8'd0;
      data_q   <= 1'b1;
      idx_q    <= 4'd0;
      done_q   <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

  assign bus.nesData    = data_q;
  assign bus.frameDone  = done_q;
  assign bus.bitIndex   = idx_q;
  assign bus.frameCount = count_q;

endmodule

`default_nettype wire

// File: tb/tb_nes_controller_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_nes_controller_emulator
// Brief    : Frame-level reference model driving SYNC_STAGES=2 and =3 pads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nes_controller_emulator;

  localparam int PH = 6;

  logic       clk;
  logic       reset;
  logic       latch_r;
  logic       nclk_r;
  logic [7:0] btn_r;

  nes_controller_emulator_if bus2 ();
  nes_controller_emulator_if bus3 ();

  assign bus2.nesLatch = latch_r;
  assign bus2.nesClk   = nclk_r;
  assign bus2.buttons  = btn_r;
  assign bus3.nesLatch = latch_r;
  assign bus3.nesClk   = nclk_r;
  assign bus3.buttons  = btn_r;

  nes_controller_emulator #(.SYNC_STAGES(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));
  nes_controller_emulator #(.SYNC_STAGES(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame model: captured byte, clocks seen since the latch, completed frames.
  int         n_cmp;
  int         n_bad;
  int         k;
  logic [7:0] cap;
  bit         active;
  int         frames;
  int         exp_done;
  int         fd2;
  int         fd3;
  logic [7:0] rx2;
  logic [7:0] rx3;

  always @(negedge clk) begin
    if (bus2.frameDone === 1'b1) fd2++;
    if (bus3.frameDone === 1'b1) fd3++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    logic [31:0] ed;
    logic [31:0] ei;
    logic [31:0] ec;
    if (!active) begin
      ed = 1; ei = 0;
    end else if (k < 8) begin
      ed = {31'd0, ~cap[k]}; ei = k;
    end else begin
      ed = 1; ei = 8;
    end
    ec = frames % 256;
    check_val({tag, "/data2"}, {31'd0, bus2.nesData}, ed);
    check_val({tag, "/data3"}, {31'd0, bus3.nesData}, ed);
    check_val({tag, "/idx2"}, {28'd0, bus2.bitIndex}, ei);
    check_val({tag, "/idx3"}, {28'd0, bus3.bitIndex}, ei);
    check_val({tag, "/cnt2"}, {24'd0, bus2.frameCount}, ec);
    check_val({tag, "/cnt3"}, {24'd0, bus3.frameCount}, ec);
  endtask

  task automatic wait_ph();
    repeat (PH) @(posedge clk);
    #1;
  endtask

  // Latch pulse: 'pre' is shown first, 'btns' is what is held at the falling edge.
  task automatic latch_phase(input logic [7:0] pre, input logic [7:0] btns, input bit coincide);
    if (coincide) begin
      nclk_r = 1'b0;
      wait_ph();
    end
    btn_r   = pre;
    latch_r = 1'b1;
    if (coincide) nclk_r = 1'b1;
    wait_ph();
    btn_r = btns;
    wait_ph();
    active = 1'b1;
    k      = 0;
    cap    = btns;
    check_state("load");
    latch_r = 1'b0;
    wait_ph();
    check_state("latched");
  endtask

  // Host-side reader: sample nesData before each rising nesClk.
  task automatic shift_clocks(input int n, input bit full);
    rx2 = 8'd0;
    rx3 = 8'd0;
    for (int i = 0; i < n; i++) begin
      if (i < 8) begin
        rx2[i] = ~bus2.nesData;
        rx3[i] = ~bus3.nesData;
      end
      nclk_r = 1'b0;
      btn_r  = 8'($urandom);
      wait_ph();
      nclk_r = 1'b1;
      wait_ph();
      if (active && k < 8) begin
        k++;
        if (k == 8) begin
          frames++;
          exp_done++;
        end
      end
      if (full) check_state("shift");
    end
    if (active && n >= 8) begin
      check_val("rx2", {24'd0, rx2}, {24'd0, cap});
      check_val("rx3", {24'd0, rx3}, {24'd0, cap});
    end
    check_val("fdone2", fd2, exp_done);
    check_val("fdone3", fd3, exp_done);
    if (!full) check_state("end");
  endtask

  task automatic apply_reset();
    #2 reset = 1'b1;
    #1;
    active = 1'b0;
    frames = 0;
    k      = 0;
    check_state("async_rst");
    check_val("rst_fd2", {31'd0, bus2.frameDone}, 0);
    check_val("rst_fd3", {31'd0, bus3.frameDone}, 0);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e2;
    int e3;
    n_cmp = 0; n_bad = 0; k = 0; cap = 8'd0; active = 1'b0;
    frames = 0; exp_done = 0; fd2 = 0; fd3 = 0;
    reset = 1'b1; latch_r = 1'b0; nclk_r = 1'b1; btn_r = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Latch-to-output latency: SYNC_STAGES+2 edges counting the first sampling edge.
    btn_r   = 8'h01;
    latch_r = 1'b1;
    e2 = 0; e3 = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      if (e2 == 0 && bus2.nesData === 1'b0) e2 = e;
      if (e3 == 0 && bus3.nesData === 1'b0) e3 = e;
    end
    check_val("latency2", e2, 4);
    check_val("latency3", e3, 5);
    active = 1'b1; k = 0; cap = 8'h01;
    latch_r = 1'b0;
    wait_ph();
    check_state("latched");
    shift_clocks(8, 1'b1);

    // Basic frame (A + Start), then continuous load 00 -> FF.
    latch_phase(8'h09, 8'h09, 1'b0);
    shift_clocks(8, 1'b1);
    latch_phase(8'h00, 8'hFF, 1'b0);
    shift_clocks(8, 1'b1);

    // Overflow clocks beyond the 8th bit.
    latch_phase(8'($urandom), 8'($urandom), 1'b0);
    shift_clocks(12, 1'b1);

    // Clocks with no latch after reset.
    apply_reset();
    shift_clocks(3, 1'b1);

    // Abort after 3 clocks, then a full frame.
    latch_phase(8'($urandom), 8'($urandom), 1'b0);
    shift_clocks(3, 1'b1);
    latch_phase(8'($urandom), 8'($urandom), 1'b0);
    shift_clocks(8, 1'b1);

    // Latch and clock rising together, from mid-frame.
    latch_phase(8'($urandom), 8'($urandom), 1'b0);
    shift_clocks(5, 1'b1);
    latch_phase(8'($urandom), 8'($urandom), 1'b1);
    shift_clocks(8, 1'b1);

    // Reset in the middle of a shift.
    latch_phase(8'($urandom), 8'($urandom), 1'b0);
    shift_clocks(4, 1'b1);
    apply_reset();
    latch_phase(8'($urandom), 8'($urandom), 1'b0);
    shift_clocks(8, 1'b1);

    // Randomized frames: length, coincidence and button patterns.
    for (int f = 0; f < 20; f++) begin
      latch_phase(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      shift_clocks($urandom_range(1, 12), 1'b1);
    end

    // Loopback with the host reader, both synchronizer depths.
    for (int f = 0; f < 4; f++) begin
      latch_phase(8'($urandom), 8'hA5, 1'b0);
      shift_clocks(8, 1'b1);
    end

    // 256 complete frames wrap the frame counter back to 0.
    apply_reset();
    for (int f = 0; f < 256; f++) begin
      latch_phase(8'($urandom), 8'($urandom), 1'b0);
      shift_clocks(8, 1'b0);
    end
    check_val("wrap2", {24'd0, bus2.frameCount}, 0);
    check_val("wrap3", {24'd0, bus3.frameCount}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
